// File: rtl/walk_sequencer.sv
// -----------------------------------------------------------------------------
// walk_sequencer
//
// Pedestrian walk-signal sequencer for a four-lane intersection. Two identical,
// independent crossing controllers (A and B) follow their car axis signal and
// serve latched button requests with a timed WALK / FLASH sequence.
//
// Ports
//   clk           rising-edge system clock
//   rst_n         asynchronous active-low reset
//   laneAControl  axis A car signal: 00 red, 01 yellow, 10 green, 11 = red
//   laneBControl  axis B car signal, same coding
//   btnA, btnB    pedestrian request buttons (synchronous level)
//   perTime       walk duration in seconds (sampled at WALK entry)
//   handTime      flashing-hand duration in seconds (sampled at WALK entry)
//   walkA, walkB  pedestrian signal: 00 solid hand, 01 flashing hand, 10 walk
//   reqPendingA/B latched, not yet served request
//   fault         sticky conflicting-green indication (cleared only by reset)
// -----------------------------------------------------------------------------
module walk_sequencer #(
    parameter int TICKS_PER_SEC = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] laneAControl,
    input  logic [1:0] laneBControl,
    input  logic       btnA,
    input  logic       btnB,
    input  logic [5:0] perTime,
    input  logic [5:0] handTime,
    output logic [1:0] walkA,
    output logic [1:0] walkB,
    output logic       reqPendingA,
    output logic       reqPendingB,
    output logic       fault
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] TERM_COUNT = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WALK  = 2'd1,
        FLASH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Crossing inputs/outputs packed so both controllers come from one loop;
    // slice gi*2 +: 2 belongs to crossing gi (0 = A, 1 = B).
    logic [3:0] lane_bus;
    logic [1:0] btn_bus;
    logic [3:0] walk_bus;
    logic [1:0] req_bus;

    assign lane_bus = {laneBControl, laneAControl};
    assign btn_bus  = {btnB, btnA};

    assign walkA       = walk_bus[1:0];
    assign walkB       = walk_bus[3:2];
    assign reqPendingA = req_bus[0];
    assign reqPendingB = req_bus[1];

    // Conflicting greens: the fault takes effect on the very edge it is seen,
    // so both controllers are forced idle on that edge as well as afterwards.
    logic both_green;
    logic fault_reg;
    logic fault_force;

    assign both_green  = (laneAControl == 2'b10) && (laneBControl == 2'b10);
    assign fault_force = fault_reg | both_green;
    assign fault       = fault_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_reg <= 1'b0;
        end else if (both_green) begin
            fault_reg <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_xing
            logic [1:0]    ctl;
            logic          btn;
            logic          green_start;
            logic          red_like;
            logic          tick;

            state_t        state_reg, state_next;
            logic [1:0]    prev_reg;
            logic          req_reg, req_next;
            logic [5:0]    hand_reg, hand_next;
            logic [5:0]    sec_reg, sec_next;
            logic [PW-1:0] presc_reg, presc_next;
            logic [1:0]    walk_reg, walk_next;

            assign ctl         = lane_bus[gi*2 +: 2];
            assign btn         = btn_bus[gi];
            assign green_start = (ctl == 2'b10) && (prev_reg != 2'b10);
            assign red_like    = (ctl == 2'b00) || (ctl == 2'b11);
            assign tick        = (presc_reg == TERM_COUNT);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg <= IDLE;
                    prev_reg  <= 2'b00;
                    req_reg   <= 1'b0;
                    hand_reg  <= 6'd0;
                    sec_reg   <= 6'd0;
                    presc_reg <= '0;
                    walk_reg  <= 2'b00;
                end else begin
                    state_reg <= state_next;
                    prev_reg  <= ctl;
                    req_reg   <= req_next;
                    hand_reg  <= hand_next;
                    sec_reg   <= sec_next;
                    presc_reg <= presc_next;
                    walk_reg  <= walk_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                req_next   = req_reg | btn;
                hand_next  = hand_reg;
                sec_next   = sec_reg;
                presc_next = presc_reg;

                if (fault_force) begin
                    state_next = IDLE;
                    sec_next   = 6'd0;
                    presc_next = '0;
                end else begin
                    case (state_reg)
                        IDLE: begin
                            presc_next = '0;
                            // A press on this very edge counts and is consumed.
                            if (green_start && (req_reg || btn) && (perTime != 6'd0)) begin
                                state_next = WALK;
                                sec_next   = perTime;
                                hand_next  = handTime;
                                req_next   = 1'b0;
                            end
                        end

                        WALK: begin
                            // Yellow cuts the walk short but still grants the
                            // full flashing-hand time.
                            if (red_like) begin
                                state_next = IDLE;
                                sec_next   = 6'd0;
                                presc_next = '0;
                            end else if ((ctl == 2'b01) || (tick && (sec_reg == 6'd1))) begin
                                presc_next = '0;
                                if (hand_reg == 6'd0) begin
                                    state_next = DONE;
                                    sec_next   = 6'd0;
                                end else begin
                                    state_next = FLASH;
                                    sec_next   = hand_reg;
                                end
                            end else if (tick) begin
                                presc_next = '0;
                                sec_next   = sec_reg - 6'd1;
                            end else begin
                                presc_next = presc_reg + PW'(1);
                            end
                        end

                        FLASH: begin
                            if (red_like) begin
                                state_next = IDLE;
                                sec_next   = 6'd0;
                                presc_next = '0;
                            end else if (tick && (sec_reg == 6'd1)) begin
                                state_next = DONE;
                                sec_next   = 6'd0;
                                presc_next = '0;
                            end else if (tick) begin
                                presc_next = '0;
                                sec_next   = sec_reg - 6'd1;
                            end else begin
                                presc_next = presc_reg + PW'(1);
                            end
                        end

                        DONE: begin
                            presc_next = '0;
                            if (ctl != 2'b10) begin
                                state_next = IDLE;
                            end
                        end

                        default: begin
                            state_next = IDLE;
                        end
                    endcase
                end

                // Registered output follows the state being entered.
                case (state_next)
                    WALK:    walk_next = 2'b10;
                    FLASH:   walk_next = 2'b01;
                    default: walk_next = 2'b00;
                endcase
            end

            assign walk_bus[gi*2 +: 2] = walk_reg;
            assign req_bus[gi]         = req_reg;
        end
    endgenerate

endmodule

// File: tb/tb_walk_sequencer.sv
// -----------------------------------------------------------------------------
// tb_walk_sequencer
//
// Drives walk_sequencer with TICKS_PER_SEC=4 through directed scenarios and a
// long randomized run. A phase/remaining-cycles reference model predicts every
// output each cycle; one line is printed per failing comparison.
// -----------------------------------------------------------------------------
module tb_walk_sequencer;

    localparam int TPS = 4;

    localparam int M_IDLE  = 0;
    localparam int M_WALK  = 1;
    localparam int M_FLASH = 2;
    localparam int M_DONE  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] laneA = 2'b00;
    logic [1:0] laneB = 2'b00;
    logic       bA = 1'b0;
    logic       bB = 1'b0;
    logic [5:0] pt = 6'd0;
    logic [5:0] ht = 6'd0;
    logic [1:0] walkA, walkB;
    logic       reqA, reqB, faultO;

    walk_sequencer #(.TICKS_PER_SEC(TPS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .laneAControl (laneA),
        .laneBControl (laneB),
        .btnA         (bA),
        .btnB         (bB),
        .perTime      (pt),
        .handTime     (ht),
        .walkA        (walkA),
        .walkB        (walkB),
        .reqPendingA  (reqA),
        .reqPendingB  (reqB),
        .fault        (faultO)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int       ph [2];
    int       rem[2];
    int       lh [2];
    bit       rq [2];
    bit [1:0] pv [2];
    bit       mf;

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            ph[i] = M_IDLE; rem[i] = 0; lh[i] = 0; rq[i] = 0; pv[i] = 2'b00;
        end
        mf = 0;
    endfunction

    function automatic void start_flash(int i);
        if (lh[i] == 0) ph[i] = M_DONE;
        else begin ph[i] = M_FLASH; rem[i] = lh[i] * TPS; end
    endfunction

    function automatic void model_step();
        bit [1:0] ln[2];
        bit       bt[2];
        bit       bothg, gs, nr, redish;
        ln[0] = laneA; ln[1] = laneB;
        bt[0] = bA;    bt[1] = bB;
        bothg = (ln[0] == 2) && (ln[1] == 2);
        for (int i = 0; i < 2; i++) begin
            gs     = (ln[i] == 2) && (pv[i] != 2);
            nr     = rq[i] | bt[i];
            redish = (ln[i] == 0) || (ln[i] == 3);
            if (mf || bothg) ph[i] = M_IDLE;
            else begin
                case (ph[i])
                    M_IDLE: if (gs && nr && pt != 0) begin
                        ph[i] = M_WALK; rem[i] = int'(pt) * TPS; lh[i] = int'(ht); nr = 0;
                    end
                    M_WALK: begin
                        if (redish) ph[i] = M_IDLE;
                        else if (ln[i] == 1) start_flash(i);
                        else begin
                            rem[i]--;
                            if (rem[i] == 0) start_flash(i);
                        end
                    end
                    M_FLASH: begin
                        if (redish) ph[i] = M_IDLE;
                        else begin
                            rem[i]--;
                            if (rem[i] == 0) ph[i] = M_DONE;
                        end
                    end
                    default: if (ln[i] != 2) ph[i] = M_IDLE;
                endcase
            end
            rq[i] = nr;
            pv[i] = ln[i];
        end
        if (bothg) mf = 1;
    endfunction

    function automatic logic [1:0] ew(int i);
        return (ph[i] == M_WALK) ? 2'b10 : (ph[i] == M_FLASH) ? 2'b01 : 2'b00;
    endfunction

    function automatic logic [31:0] exp_vec();
        return {25'd0, ew(0), ew(1), rq[0], rq[1], mf};
    endfunction

    function automatic logic [31:0] obs_vec();
        return {25'd0, walkA, walkB, reqA, reqB, faultO};
    endfunction

    // One clock: model advances on the edge, outputs compared at the negedge.
    task automatic step(input string tag);
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        check(tag, obs_vec(), exp_vec());
    endtask

    // Called at a negedge: asserts reset mid-cycle, checks outputs drop without
    // an edge, holds two cycles, then releases away from the clock edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst", obs_vec(), exp_vec());
        check("rst_walkA", walkA, 2'b00);
        check("rst_reqA", reqA, 1'b0);
        repeat (2) step("in_rst");
        #2 rst_n = 1'b1;
    endtask

    function automatic logic [1:0] pick_lane();
        int r;
        r = $urandom_range(0, 9);
        if (r < 2) return 2'b00;
        if (r == 2) return 2'b01;
        if (r == 3) return 2'b11;
        return 2'b10;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc, fc, hA, hB;
        bit fault_ok;
        model_reset();
        @(negedge clk);
        check("reset", obs_vec(), 32'd0);
        #2 rst_n = 1'b1;

        // Request while red, then a green start: 3 s walk, 2 s flash.
        pt = 6'd3; ht = 6'd2;
        bA = 1'b1; step("btn");
        bA = 1'b0;
        check("reqA_set", reqA, 1'b1);
        repeat (2) step("red");
        laneA = 2'b10;
        wc = 0; fc = 0;
        for (int i = 0; i < 30; i++) begin
            step("basic");
            if (i == 0) check("reqA_clr", reqA, 1'b0);
            if (walkA == 2'b10) wc++;
            if (walkA == 2'b01) fc++;
        end
        check("walk_cycles", wc, 12);
        check("flash_cycles", fc, 8);

        // Green with no request: nothing; a press during green waits for the next start.
        laneA = 2'b00; repeat (2) step("red2");
        laneA = 2'b10; wc = 0;
        for (int i = 0; i < 10; i++) begin
            step("noreq");
            if (walkA != 2'b00) wc++;
        end
        check("noreq_walk", wc, 0);
        bA = 1'b1; step("late_btn"); bA = 1'b0;
        check("late_pend", reqA, 1'b1);
        laneA = 2'b00; repeat (2) step("red3");
        laneA = 2'b10; step("served");
        check("served_walk", walkA, 2'b10);

        // Yellow after 5 walk cycles -> full flash; then red abort during flash.
        repeat (4) step("walk5");
        laneA = 2'b01; step("yellow");
        check("yellow_flash", walkA, 2'b01);
        fc = 1;
        for (int i = 0; i < 20; i++) begin
            step("yflash");
            if (walkA == 2'b01) fc++;
            else break;
        end
        check("yflash_cycles", fc, 8);
        laneA = 2'b00; step("red4");
        laneA = 2'b10; bA = 1'b1; step("consume");
        bA = 1'b0;
        check("consumed", reqA, 1'b0);
        repeat (14) step("walk_to_flash");
        check("in_flash", walkA, 2'b01);
        laneA = 2'b00; step("abort");
        check("red_abort", walkA, 2'b00);

        // perTime=0 keeps request; handTime=0 goes straight to DONE.
        pt = 6'd0;
        bA = 1'b1; step("pt0_btn"); bA = 1'b0;
        laneA = 2'b10; step("pt0");
        check("pt0_nowalk", walkA, 2'b00);
        check("pt0_pending", reqA, 1'b1);
        pt = 6'd2; ht = 6'd0;
        laneA = 2'b00; step("red5");
        laneA = 2'b10; step("ht0_entry");
        wc = 1; fc = 0;
        for (int i = 0; i < 12; i++) begin
            step("ht0");
            if (walkA == 2'b10) wc++;
            if (walkA == 2'b01) fc++;
        end
        check("ht0_walk", wc, 8);
        check("ht0_flash", fc, 0);

        // Reset mid-flash, green held through release with a fresh press.
        pt = 6'd1; ht = 6'd2;
        laneA = 2'b00; step("red6");
        laneA = 2'b10; bA = 1'b1; step("w1"); bA = 1'b0;
        repeat (5) step("to_flash");
        check("mid_flash", walkA, 2'b01);
        bA = 1'b1; step("flash_btn");
        check("flash_pend", reqA, 1'b1);
        do_reset();
        step("post_rst_green");
        check("post_rst_walk", walkA, 2'b10);
        bA = 1'b0;

        // Conflicting greens.
        laneA = 2'b00; laneB = 2'b00; repeat (2) step("red7");
        laneA = 2'b10; laneB = 2'b10; step("conflict");
        check("fault_set", faultO, 1'b1);
        laneB = 2'b00; bA = 1'b1; step("fault_btn"); bA = 1'b0;
        laneA = 2'b00; step("fault_red");
        laneA = 2'b10; step("fault_green");
        check("fault_block", walkA, 2'b00);
        check("fault_req", reqA, 1'b1);
        repeat (5) step("fault_hold");
        do_reset();
        laneA = 2'b00;
        step("fault_clr");
        check("fault_cleared", faultO, 1'b0);

        // Randomized run.
        hA = 0; hB = 0; fault_ok = 0;
        for (int c = 0; c < 3000; c++) begin
            fault_ok = (c > 2500);
            if (hA == 0) begin
                laneA = pick_lane();
                hA = (laneA == 2'b10) ? $urandom_range(8, 50) : $urandom_range(1, 12);
            end else hA--;
            if (hB == 0) begin
                laneB = pick_lane();
                hB = (laneB == 2'b10) ? $urandom_range(8, 50) : $urandom_range(1, 12);
            end else hB--;
            if (laneA == 2'b10 && laneB == 2'b10 && !fault_ok) laneB = 2'b00;
            bA = ($urandom_range(0, 9) == 0);
            bB = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 29) == 0) pt = 6'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) ht = 6'($urandom_range(0, 3));
            step("rand");
            if ($urandom_range(0, 599) == 0 || c == 2800) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/walk_sequencer.md
WALK_SEQUENCER -- requirements
Module: walk_sequencer

Interface
REQ-001 Parameter TICKS_PER_SEC, default 5000, sets clock cycles per timing second.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 laneAControl  input  2  car signal code for axis A (lanes 1,2): 00 red, 01 yellow, 10 green, 11 illegal and treated as red.
REQ-005 laneBControl  input  2  car signal code for axis B (lanes 3,4), same coding.
REQ-006 btnA, btnB  input  1 each  pedestrian request buttons for the crossings parallel to axis A / axis B, synchronous level.
REQ-007 perTime  input  6  walk duration in seconds.
REQ-008 handTime  input  6  flashing-hand duration in seconds.
REQ-009 walkA, walkB  output  2 each  pedestrian signal code: 00 solid hand, 01 flashing hand, 10 walk person; 11 never driven.
REQ-010 reqPendingA, reqPendingB  output  1 each  latched unserved request.
REQ-011 fault  output  1  sticky conflicting-green indication.

Function
REQ-012 The block SHALL contain two identical, independent crossing FSMs X in {A,B}, each with states IDLE, WALK, FLASH, DONE; all outputs registered.
REQ-013 Each FSM SHALL register laneXControl into prevX each cycle; greenStartX = (laneXControl==10) && (prevX!=10).
REQ-014 reqPendingX SHALL set on any edge where btnX=1 and clear on the edge that enters WALK; a press on the entering edge is consumed.
REQ-015 IDLE: walkX=00; on greenStartX with (reqPendingX or btnX) and perTime!=0, go WALK, latching perTime and handTime; otherwise stay IDLE and keep the request pending for the next green start.
REQ-016 Timing: per-FSM prescaler counts 0..TICKS_PER_SEC-1, cleared on entry to WALK/FLASH; at terminal count it decrements a 6-bit seconds counter.
REQ-017 WALK: walkX=10 from the first cycle after the entering edge, for exactly latched perTime*TICKS_PER_SEC cycles, then FLASH with seconds loaded from latched handTime; if latched handTime==0, go DONE instead.
REQ-018 FLASH: walkX=01 for exactly latched handTime*TICKS_PER_SEC cycles, then DONE.
REQ-019 DONE: walkX=00; go IDLE when laneXControl!=10; a request arriving in DONE stays pending.
REQ-020 laneXControl==01 while in WALK SHALL force immediate FLASH, reloading the full latched handTime (or DONE if zero).
REQ-021 laneXControl 00 or 11 while in WALK, FLASH or DONE SHALL force IDLE with walkX=00 on the next cycle.
REQ-022 Time inputs changing mid-phase SHALL NOT affect the current phase; only latched values are used.
REQ-023 laneAControl==10 and laneBControl==10 on the same edge SHALL set fault=1 and force both FSMs to IDLE; while fault=1 both walk outputs stay 00 and no green start is accepted; requests still latch.
REQ-024 Simultaneous greenStartX and exit conditions cannot occur; simultaneous events on A and B SHALL be processed independently in the same cycle.

Reset
REQ-025 rst_n low SHALL asynchronously force both FSMs to IDLE, walkA=walkB=00, reqPendingA=reqPendingB=0, fault=0, prescalers and seconds counters to 0, prevA=prevB=00.
REQ-026 A green present on the first edge after reset release SHALL count as a green start.
REQ-027 Reset asserted mid-WALK or mid-FLASH SHALL drop walk outputs to 00 without waiting for a clock edge.

Verification (TICKS_PER_SEC=4)
REQ-028 btnA pulse while laneA red, then laneA 00->10, perTime=3, handTime=2 -> walkA=10 for 12 cycles, 01 for 8 cycles, then 00; reqPendingA 1 until WALK entry.
REQ-029 laneA 00->10 with no request -> walkA stays 00 whole green; btnA during that green -> reqPendingA=1, served at next green start.
REQ-030 In WALK with 5 cycles elapsed, laneA->01 -> walkA=01 next cycle for full 8 cycles; laneA->00 during FLASH -> walkA=00 next cycle.
REQ-031 laneA and laneB both 10 -> fault=1, walkA=walkB=00, held until rst_n low; rst_n release clears fault.
REQ-032 perTime=0 with request -> no WALK, request stays pending; handTime=0 -> WALK then direct DONE (walk 10 -> 00).
REQ-033 rst_n low mid-FLASH -> walkA=00 and reqPendingA=0 immediately; green held across release -> new green start accepted.
